// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply/divide unit with a start/done handshake and HI/LO results.
// Optional build macro MDU_EARLY_EXIT_EN: MULT/MULTU leave RUN once the remaining multiplier is zero.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t state, stateNext;

  logic [WIDTH-1:0]   opA, opB;
  logic [1:0]         opReg;
  logic               negMain, negRem;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic               isDiv, isSigned, aNeg, bNeg, divZero, lastIter, runExit, divGe;
  logic [WIDTH-1:0]   magA, magB, mplierNext, divTrial, newRem, fixQ, fixR;
  logic [WIDTH:0]     divShift;
  logic [2*WIDTH-1:0] fixProd;

  always_comb begin
    isDiv    = opReg[1];
    isSigned = ~opReg[0];
    aNeg     = isSigned & opA[WIDTH-1];
    bNeg     = isSigned & opB[WIDTH-1];
    // |MIN| keeps the MIN bit pattern, which is the correct unsigned magnitude
    magA     = aNeg ? -opA : opA;
    magB     = bNeg ? -opB : opB;
    divZero  = isDiv && (opB == '0);

    mplierNext = mplier >> 1;
    lastIter   = (cnt == CW'(WIDTH - 1));
`ifdef MDU_EARLY_EXIT_EN
    runExit    = lastIter || (!isDiv && (mplierNext == '0));
`else
    runExit    = lastIter;
`endif

    // Restoring step: acc holds {remainder, dividend/quotient}; divisor sits in mcand low half
    divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    divGe    = (divShift >= {1'b0, mcand[WIDTH-1:0]});
    divTrial = divShift[WIDTH-1:0] - mcand[WIDTH-1:0];
    newRem   = divGe ? divTrial : divShift[WIDTH-1:0];

    fixProd = negMain ? -acc : acc;
    fixQ    = negMain ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    fixR    = negRem  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) stateNext = PREP;
      PREP: begin
        busy      = 1'b1;
        stateNext = divZero ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (runExit) stateNext = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opA     <= '0;
      opB     <= '0;
      opReg   <= '0;
      negMain <= 1'b0;
      negRem  <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      div0    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          opA   <= a;
          opB   <= b;
          opReg <= op;
          div0  <= 1'b0;
        end
        PREP: begin
          if (divZero) begin
            div0 <= 1'b1;
          end else begin
            negMain <= aNeg ^ bNeg;
            negRem  <= aNeg;
            cnt     <= '0;
            if (isDiv) begin
              acc   <= {{WIDTH{1'b0}}, magA};
              mcand <= {{WIDTH{1'b0}}, magB};
            end else begin
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, magA};
              mplier <= magB;
            end
          end
        end
        RUN: begin
          cnt <= runExit ? '0 : cnt + CW'(1);
          if (isDiv) begin
            acc <= {newRem, acc[WIDTH-2:0], divGe};
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplierNext;
          end
        end
        FIX: begin
          if (isDiv) begin
            hi <= fixR;
            lo <= fixQ;
          end else begin
            hi <= fixProd[2*WIDTH-1:WIDTH];
            lo <= fixProd[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: vector table plus reset/busy/WIDTH=8 sequences.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, div0;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8, div08;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div0(div0)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div0(div08)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected FIX->DONE edge number, counting the start-sampling edge as 0
  function automatic int expLat(input logic [1:0] o, input logic [31:0] bb, input logic dz);
    if (dz) return 1;
`ifdef MDU_EARLY_EXIT_EN
    if (!o[1]) begin
      logic [31:0] m;
      int n;
      m = (!o[0] && bb[31]) ? -bb : bb;
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      return n + 2;
    end
`endif
    return 34;
  endfunction

  task automatic waitIdle();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy && !done) return;
    end
    check("waitIdle timeout", 1, 0);
  endtask

  task automatic runOp(input int idx, input logic [1:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, output int lat);
    waitIdle();
    op = o; a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("v%0d busyAccept", idx), busy, 1);
    check($sformatf("v%0d div0Accept", idx), div0, 0);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;

    vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[7]  = '{2'b10, 32'h00000005, 32'h00000000, 32'h00000001, 32'h00000003, 1'b1};
    vecs[8]  = '{2'b11, 32'h00000009, 32'h00000003, 32'h00000000, 32'h00000003, 1'b0};
    vecs[9]  = '{2'b00, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
    vecs[10] = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[11] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[12] = '{2'b10, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0};
    vecs[13] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[14] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[15] = '{2'b00, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0};

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset div0", div0, 0);
    check("reset8 hilo", {hi8, lo8, busy8, done8, div08}, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      runOp(i, vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d latency", i), lat, expLat(vecs[i].op, vecs[i].b, vecs[i].dz));
      check($sformatf("v%0d hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d div0", i), div0, vecs[i].dz);
      check($sformatf("v%0d busyDone", i), busy, 0);
    end

    // start raised while busy must be ignored: exactly one done, results of the first op
    waitIdle();
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
    repeat (15) @(posedge clk);
    #1;
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("busyStart pulses", pulses, 1);
    check("busyStart hi", hi, 32'd2);
    check("busyStart lo", lo, 32'd14);
    check("busyStart idle", busy, 0);

    // reset pulsed during RUN iteration 10
    waitIdle();
    op = 2'b01; a = 32'h0000000F; b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("preReset busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midReset busy", busy, 0);
    check("midReset done", done, 0);
    check("midReset hi", hi, 0);
    check("midReset lo", lo, 0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("midReset noDone", pulses, 0);

    // WIDTH=8 instance
    @(negedge clk);
    op8 = 2'b01; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = k;
        break;
      end
    end
    check("w8 latency", lat, 10);
    check("w8 hi", hi8, 8'hFE);
    check("w8 lo", lo8, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
